// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the core memory-port arbiter.
//                - arb_state_e : arbiter FSM states (IDLE / ISSUE / WAIT)
//                - arb_owner_e : owner of the in-flight transaction (IF / LS)
//                - STREAK_MAX_DEFAULT, STREAK_W : anti-starvation counter
//                - streak_next() : saturating streak increment
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam int STREAK_MAX_DEFAULT = 4;

    // Wide enough for the largest legal limit (15).
    localparam int STREAK_W = 4;

    // Count one more LSU grant, never going past the limit.
    function automatic logic [STREAK_W-1:0] streak_next(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] lim
    );
        return (cur >= lim) ? lim : cur + 4'd1;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : arb_prio_sel
//  Description : Combinational winner select between instruction fetch and
//                the load/store unit. LSU normally wins; once it has won
//                STREAK_MAX times in a row while IF was waiting, IF is owed
//                the next grant. A flushing IF request is not eligible.
//  Ports       : if_valid  in  IF request pending
//                ls_valid  in  LSU request pending
//                if_flush  in  redirect this cycle (IF not eligible)
//                streak    in  consecutive LSU grants while IF waited
//                grant_if  out IF wins this cycle
//                grant_ls  out LSU wins this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
    input  logic                if_valid,
    input  logic                ls_valid,
    input  logic                if_flush,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_if,
    output logic                grant_ls
);

    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

    logic if_eligible;
    logic if_owed;

    assign if_eligible = if_valid & ~if_flush;
    assign if_owed     = if_eligible & (streak == STREAK_LIM);

    assign grant_ls = ls_valid & ~if_owed;
    assign grant_if = if_eligible & ~grant_ls;

endmodule : arb_prio_sel
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single core memory port between instruction fetch
//                and the load/store unit, one transaction outstanding at a
//                time. LSU has priority, bounded by an IF anti-starvation
//                streak counter. In-flight IF responses can be dropped by a
//                redirect (if_flush).
//  Ports       : clk, rst (async, active-low)
//                if_req_valid/if_req_ready/if_addr/if_flush  IF request side
//                if_resp_valid/if_resp_data                  IF response (32b)
//                ls_req_valid/ls_req_ready/ls_wen/ls_addr/
//                ls_wdata/ls_wmask                           LSU request side
//                ls_resp_valid/ls_resp_data                  LSU response
//                mem_req/mem_gnt/mem_we/mem_addr/mem_wdata/
//                mem_wmask/mem_rvalid/mem_rdata              memory port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_resp_valid,
    output logic [31:0]         if_resp_data,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,

    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

    arb_state_e          state;
    arb_owner_e          owner;
    logic                drop;
    logic [STREAK_W-1:0] streak;
    logic                if_hi_word;    // latched if_addr[2]: upper 32b lane

    logic                grant_if;
    logic                grant_ls;
    logic                idle;
    logic                if_cancel;
    logic                unused_if_addr_lo;

    // Byte offset inside the word is implied by alignment.
    assign unused_if_addr_lo = ^if_addr[1:0];

    arb_prio_sel #(
        .STREAK_MAX (STREAK_MAX)
    ) u_prio_sel (
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .if_flush (if_flush),
        .streak   (streak),
        .grant_if (grant_if),
        .grant_ls (grant_ls)
    );

    // Readys are only offered in IDLE, and never while reset is held.
    assign idle         = (state == ST_IDLE) && rst;
    assign if_req_ready = idle & grant_if;
    assign ls_req_ready = idle & grant_ls;

    // A redirect seen any time the fetch is in flight kills its response,
    // including the very cycle the data comes back.
    assign if_cancel = drop | if_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            owner         <= OWN_IF;
            drop          <= 1'b0;
            streak        <= '0;
            if_hi_word    <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
        end else begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    drop <= 1'b0;
                    if (grant_ls) begin
                        state     <= ST_ISSUE;
                        owner     <= OWN_LS;
                        mem_req   <= 1'b1;
                        mem_we    <= ls_wen;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        mem_wmask <= ls_wmask;
                        // Only grants that made IF wait count toward the streak.
                        streak    <= if_req_valid ? streak_next(streak, STREAK_LIM) : '0;
                    end else if (grant_if) begin
                        state      <= ST_ISSUE;
                        owner      <= OWN_IF;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {if_addr[ADDR_W-1:3], 3'b000};
                        mem_wdata  <= '0;
                        mem_wmask  <= '1;
                        if_hi_word <= if_addr[2];
                        streak     <= '0;
                    end
                end

                ST_ISSUE: begin
                    if ((owner == OWN_IF) && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if ((owner == OWN_IF) && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state <= ST_IDLE;
                        drop  <= 1'b0;
                        if (owner == OWN_LS) begin
                            ls_resp_valid <= 1'b1;
                            ls_resp_data  <= mem_we ? '0 : mem_rdata;
                        end else if (!if_cancel) begin
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= if_hi_word ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A transaction-level
//                model predicts every output each cycle; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int STREAK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
    logic [63:0] if_addr;
    logic [31:0] if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_resp_data;
    logic [7:0]  ls_wmask;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STREAK_MAX (STREAK_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_flush      (if_flush),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_wen        (ls_wen),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_wmask      (ls_wmask),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_data  (ls_resp_data),
        .mem_req       (mem_req),
        .mem_gnt       (mem_gnt),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a transaction is either absent, waiting for
    // the memory to accept it, or waiting for its response.
    // ------------------------------------------------------------------
    bit          m_busy, m_accepted, m_is_ls, m_cancel, m_we, m_hi;
    bit          m_req, m_if_pulse, m_ls_pulse;
    int          m_streak;
    logic [63:0] m_addr, m_wdata, m_ls_data;
    logic [7:0]  m_wmask;
    logic [31:0] m_if_data;

    // 0 = nobody, 1 = IF, 2 = LSU
    function automatic int winner();
        bit if_ok;
        if_ok = if_req_valid && !if_flush;
        if (if_ok && m_streak >= STREAK_MAX) return 1;
        if (ls_req_valid) return 2;
        if (if_ok) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_accepted = 0; m_is_ls = 0; m_cancel = 0; m_we = 0; m_hi = 0;
            m_req = 0; m_if_pulse = 0; m_ls_pulse = 0; m_streak = 0;
            m_addr = '0; m_wdata = '0; m_wmask = '0; m_ls_data = '0; m_if_data = '0;
        end else begin
            int w;
            m_if_pulse = 0;
            m_ls_pulse = 0;
            if (!m_busy) begin
                w = winner();
                if (w == 2) begin
                    m_busy = 1; m_accepted = 0; m_is_ls = 1; m_cancel = 0; m_req = 1;
                    m_we = ls_wen; m_addr = ls_addr; m_wdata = ls_wdata; m_wmask = ls_wmask;
                    if (if_req_valid) m_streak = (m_streak < STREAK_MAX) ? m_streak + 1 : STREAK_MAX;
                    else m_streak = 0;
                end else if (w == 1) begin
                    m_busy = 1; m_accepted = 0; m_is_ls = 0; m_cancel = 0; m_req = 1;
                    m_we = 0; m_addr = {if_addr[63:3], 3'b000}; m_wdata = '0; m_wmask = 8'hFF;
                    m_hi = if_addr[2];
                    m_streak = 0;
                end
            end else begin
                if (!m_is_ls && if_flush) m_cancel = 1;
                if (!m_accepted) begin
                    if (mem_gnt) begin m_accepted = 1; m_req = 0; end
                end else if (mem_rvalid) begin
                    m_busy = 0;
                    if (m_is_ls) begin
                        m_ls_pulse = 1;
                        m_ls_data  = m_we ? 64'h0 : mem_rdata;
                    end else if (!m_cancel) begin
                        m_if_pulse = 1;
                        m_if_data  = m_hi ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            int w;
            w = (!rst || m_busy) ? 0 : winner();
            chk("if_req_ready", 64'(if_req_ready), 64'(w == 1));
            chk("ls_req_ready", 64'(ls_req_ready), 64'(w == 2));
            chk("mem_req", 64'(mem_req), 64'(m_req));
            chk("mem_we", 64'(mem_we), 64'(m_we));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
            chk("if_resp_valid", 64'(if_resp_valid), 64'(m_if_pulse));
            chk("ls_resp_valid", 64'(ls_resp_valid), 64'(m_ls_pulse));
            if (m_if_pulse) chk("if_resp_data", 64'(if_resp_data), 64'(m_if_data));
            if (m_ls_pulse) chk("ls_resp_data", ls_resp_data, m_ls_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    bit          auto_mem = 0;
    logic        last_gnt = 1'b0;
    logic [63:0] auto_data = 64'h1111_2222_3333_4444;

    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            // Immediate grant, response one cycle after the grant.
            mem_rvalid = last_gnt;
            mem_rdata  = auto_data;
            auto_data  = auto_data + 64'h0101_0101_0101_0101;
            mem_gnt    = mem_req;
            last_gnt   = mem_gnt;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int g_kind[$];
    int g_cyc[$];

    initial begin
        if_req_valid = 0; if_addr = '0; if_flush = 0;
        ls_req_valid = 0; ls_wen = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset mem_req", 64'(mem_req), 64'h0);
        chk("reset mem_addr", mem_addr, 64'h0);
        chk("reset mem_wmask", 64'(mem_wmask), 64'h0);
        chk("reset resp_valid", 64'({if_resp_valid, ls_resp_valid}), 64'h0);
        chk("reset readys", 64'({if_req_ready, ls_req_ready}), 64'h0);
        rst = 1;
        chk_en = 1;

        // ---------------- IF fetch, minimum latency ----------------
        cycle();
        if_req_valid = 1; if_addr = 64'h8000_0004;
        @(negedge clk) chk("t1 if_req_ready", 64'(if_req_ready), 64'h1);
        cycle();                                  // T+1
        if_req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        chk("t1 mem_req", 64'(mem_req), 64'h1);
        chk("t1 mem_addr", mem_addr, 64'h8000_0000);
        chk("t1 mem_wmask", 64'(mem_wmask), 64'hFF);
        cycle();                                  // T+2
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h00B5_0533_0000_0013;
        cycle();                                  // T+3
        mem_rvalid = 0;
        @(negedge clk);
        chk("t1 if_resp_valid", 64'(if_resp_valid), 64'h1);
        chk("t1 if_resp_data", 64'(if_resp_data), 64'h00B5_0533);

        // ---------------- store ----------------
        cycle();
        ls_req_valid = 1; ls_wen = 1; ls_addr = 64'h1000; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        @(negedge clk) chk("t2 ls_req_ready", 64'(ls_req_ready), 64'h1);
        cycle();
        ls_req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        chk("t2 mem_we", 64'(mem_we), 64'h1);
        chk("t2 mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk("t2 mem_wmask", 64'(mem_wmask), 64'h0F);
        cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        cycle();
        mem_rvalid = 0;
        @(negedge clk);
        chk("t2 ls_resp_valid", 64'(ls_resp_valid), 64'h1);
        chk("t2 ls_resp_data", ls_resp_data, 64'h0);

        // ---------------- load, early rvalid ignored ----------------
        cycle();
        ls_req_valid = 1; ls_wen = 0; ls_addr = 64'h2008; ls_wmask = 8'hFF;
        cycle();
        ls_req_valid = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        cycle();
        mem_gnt = 0; mem_rvalid = 0;
        cycle();
        mem_rvalid = 1; mem_rdata = 64'hCAFE_F00D_1234_5678;
        @(negedge clk) chk("t3 no early resp", 64'(ls_resp_valid), 64'h0);
        cycle();
        mem_rvalid = 0;
        @(negedge clk) chk("t3 ls_resp_data", ls_resp_data, 64'hCAFE_F00D_1234_5678);

        // ---------------- contention / streak ----------------
        cycle();
        ls_req_valid = 1; ls_wen = 0; ls_addr = 64'h3000;
        if_req_valid = 1; if_addr = 64'h100;
        auto_mem = 1; last_gnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ls_req_ready) begin g_kind.push_back(2); g_cyc.push_back(i); end
            if (if_req_ready) begin g_kind.push_back(1); g_cyc.push_back(i); end
            cycle();
        end
        ls_req_valid = 0; if_req_valid = 0;
        repeat (5) cycle();
        auto_mem = 0; mem_gnt = 0; mem_rvalid = 0;
        chk("t4 grant count", 64'(g_kind.size() >= 10), 64'h1);
        for (int k = 0; k < 10 && k < g_kind.size(); k++)
            chk("t4 grant order", 64'(g_kind[k]), (k % 5 == 4) ? 64'd1 : 64'd2);
        for (int k = 0; k < 4 && k + 1 < g_cyc.size(); k++)
            chk("t4 grant spacing", 64'(g_cyc[k+1] - g_cyc[k]), 64'd3);

        // ---------------- flush in WAIT, then flush in IDLE ----------------
        cycle();
        if_req_valid = 1; if_addr = 64'h44;
        cycle();
        if_req_valid = 0; mem_gnt = 1;
        cycle();
        mem_gnt = 0; if_flush = 1;
        cycle();
        if_flush = 0; mem_rvalid = 1; mem_rdata = 64'h5555_6666_7777_8888;
        cycle();
        mem_rvalid = 0;
        @(negedge clk) chk("t5 flushed no resp", 64'(if_resp_valid), 64'h0);
        if_req_valid = 1; if_flush = 1;
        @(negedge clk) chk("t5 flush blocks ready", 64'(if_req_ready), 64'h0);
        cycle();
        if_flush = 0;
        @(negedge clk) chk("t5 ready after flush", 64'(if_req_ready), 64'h1);
        cycle();
        if_req_valid = 0; mem_gnt = 1;
        cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hAAAA_BBBB_1111_2222;
        cycle();
        mem_rvalid = 0;
        @(negedge clk);
        chk("t5 if_resp_valid", 64'(if_resp_valid), 64'h1);
        chk("t5 if_resp_data hi", 64'(if_resp_data), 64'hAAAA_BBBB);

        // ---------------- grant withheld 5 cycles ----------------
        cycle();
        ls_req_valid = 1; ls_wen = 0; ls_addr = 64'h3010; ls_wmask = 8'h3C; ls_wdata = 64'h77;
        if_req_valid = 1; if_addr = 64'h200;
        cycle();
        ls_addr = 64'hFFFF; ls_wmask = 8'h01; ls_wdata = 64'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6 mem_req held", 64'(mem_req), 64'h1);
            chk("t6 mem_addr held", mem_addr, 64'h3010);
            chk("t6 mem_wmask held", 64'(mem_wmask), 64'h3C);
            chk("t6 readys low", 64'({if_req_ready, ls_req_ready}), 64'h0);
            cycle();
        end
        mem_gnt = 1;
        cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        ls_req_valid = 0; if_req_valid = 0;
        cycle();
        mem_rvalid = 0;
        @(negedge clk) chk("t6 ls_resp_data", ls_resp_data, 64'h0123_4567_89AB_CDEF);

        // ---------------- reset during WAIT ----------------
        cycle();
        ls_req_valid = 1; ls_wen = 0; ls_addr = 64'h5008; ls_wmask = 8'hFF;
        cycle();
        ls_req_valid = 0; mem_gnt = 1;
        cycle();
        mem_gnt = 0;
        #2 rst = 0;
        #1;
        chk("t7 mem_addr cleared", mem_addr, 64'h0);
        chk("t7 mem_wmask cleared", 64'(mem_wmask), 64'h0);
        chk("t7 resp data cleared", ls_resp_data | 64'(if_resp_data), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        mem_rvalid = 1; mem_rdata = 64'hFEED_FACE_FEED_FACE;
        cycle();
        mem_rvalid = 0;
        cycle();
        @(negedge clk);
        chk("t7 no resp after reset", 64'({if_resp_valid, ls_resp_valid}), 64'h0);
        chk("t7 mem_req idle", 64'(mem_req), 64'h0);

        repeat (3) cycle();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core-side memory port between instruction fetch (IF) and the load/store unit (LSU), feeding the decode stage its instruction words and the memory stage its load data. One transaction is outstanding at a time. LSU has priority, bounded by an anti-starvation counter for IF. IF responses can be dropped on a pipeline redirect.

## Interface
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: memory data width; IF word is 32 bits.
- `STREAK_MAX`, 4: max consecutive LSU grants while IF waits; range 1..15.

- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req_valid`  in  1  IF request.
- `if_req_ready`  out  1  IF request accepted this cycle (valid & ready).
- `if_addr`  in  ADDR_W  fetch address, 4-byte aligned.
- `if_flush`  in  1  redirect; cancels any in-flight IF response.
- `if_resp_valid`  out  1  one-cycle pulse, instruction returned.
- `if_resp_data`  out  32  instruction word.
- `ls_req_valid`  in  1  LSU request.
- `ls_req_ready`  out  1  LSU request accepted.
- `ls_wen`  in  1  1 = store, 0 = load.
- `ls_addr`  in  ADDR_W  load/store address.
- `ls_wdata`  in  DATA_W  store data, lane-aligned.
- `ls_wmask`  in  DATA_W/8  byte enables.
- `ls_resp_valid`  out  1  one-cycle pulse, load data or store ack.
- `ls_resp_data`  out  DATA_W  load data, 0 for stores.
- `mem_req`  out  1  request to memory, held until `mem_gnt`.
- `mem_gnt`  in  1  memory accepted request.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/ADDR_W/DATA_W/DATA_W/8  request payload, stable while `mem_req`.
- `mem_rvalid`  in  1  response/ack, at least 1 cycle after `mem_gnt`.
- `mem_rdata`  in  DATA_W  read data.

## Operation
- FSM: IDLE, ISSUE, WAIT. Register `owner` (IF/LS), `drop`, `streak`.
- IDLE: arbitrate. LSU wins if `ls_req_valid` and not (`if_req_valid` and `streak == STREAK_MAX`); otherwise IF wins if `if_req_valid`. The winner's ready is asserted combinationally, and only in IDLE. On accept, latch payload into mem_* registers, set `owner`, go to ISSUE.
- IF payload: `mem_we=0`, `mem_addr={if_addr[ADDR_W-1:3],3'b0}`, mask all-ones, wdata 0.
- `streak`: on LS grant, increment (saturating) if `if_req_valid` is high that cycle, else clear to 0. Clear it on any IF grant.
- ISSUE: `mem_req=1`. On `mem_gnt`, go to WAIT.
- WAIT: on `mem_rvalid`, register the response and go to IDLE. Raise owner's resp_valid next cycle. IF data = `mem_rdata[63:32]` if the latched `if_addr[2]`, else `[31:0]`.
- Flush: `if_flush` while owner=IF in ISSUE or WAIT sets `drop`. The transaction still completes on the memory side, but `if_resp_valid` is suppressed. `if_flush` in IDLE blocks IF acceptance that cycle. `drop` clears on return to IDLE.
- `mem_rvalid` outside WAIT is ignored and does not change state.

## Timing
- Reset (async assert, sync deassert used by system): state IDLE, `streak=0`, `drop=0`, every output 0 including data/addr registers and both readys.
- Minimum latency, accept at T: `mem_req` at T+1; if `mem_gnt` at T+1 and `mem_rvalid` at T+2, resp_valid at T+3.
- resp_valid and the IDLE return share a cycle, so the next accept may coincide with resp_valid (back-to-back throughput is one transaction per 3 cycles minimum).
- Both valid in the same IDLE cycle: exactly one ready. The loser's valid must be held by the requester (no ready means no latch).
- Reset mid-transaction: abort silently, no resp pulse. Memory side is reset by the same `rst`.
- `streak` saturates at `STREAK_MAX` and never wraps.

## Structure
- Shared package `mem_arb_pkg`: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), owner encoding (IF=0, LS=1), default `STREAK_MAX`.
- One sub-module: `arb_prio_sel`, a combinational LSU/IF winner select from both valids, `streak`, `STREAK_MAX`, `if_flush`. The FSM, payload registers and response routing stay in the top.

## Test plan
- IF only, `if_addr=0x80000004`, gnt immediate, rvalid 1 cycle later with `mem_rdata=0x00B50533_00000013` -> `mem_addr=0x80000000`, `if_resp_data=0x00B50533` at T+3.
- Store, `ls_wmask=0x0F`, `ls_wdata=0xDEADBEEF` -> mem payload matches, `mem_we=1`, `ls_resp_valid` pulse with `ls_resp_data=0`.
- Both valid continuously, `STREAK_MAX=4` -> grant order LS,LS,LS,LS,IF,LS…; `streak` resets after IF grant.
- IF in WAIT, `if_flush` pulsed, rvalid arrives -> no `if_resp_valid`; next IF request is served normally.
- `mem_gnt` withheld 5 cycles -> `mem_req` and payload stable all 5 cycles; readys stay 0.
- `rst` low during WAIT -> all outputs 0 immediately; `mem_rvalid` after release is ignored and no resp pulse follows.
